// File: rtl/golden_nonce_queue.sv
// golden_nonce_queue
//   Buffers golden nonces from the hashing core and hands them one word at a
//   time to the serial transmit stage over a send/busy handshake. Absorbs
//   bursts while the transmitter is busy and discards stale results when new
//   work arrives.
//
// Ports
//   clk          in   1         single clock, all logic on posedge
//   reset_n      in   1         synchronous active-low reset
//   nonce_in     in   32        golden nonce from the miner core
//   nonce_valid  in   1         1-cycle strobe: push nonce_in
//   flush        in   1         new-work strobe: empty the queue
//   tx_busy      in   1         busy from the serial transmitter
//   tx_send      out  1         1-cycle launch strobe (registered)
//   tx_word      out  32        word to transmit, held after launch (registered)
//   level        out  ADDR_W+1  FIFO occupancy 0..2**ADDR_W (registered)
//   overflow     out  1         sticky: a push was dropped because the queue was full
//   drop_count   out  8         dropped pushes plus timed-out launches, saturating
//
// Configuration
//   GOLDEN_NONCE_DEDUP_EN : when defined, a push equal to the last accepted
//   nonce is silently ignored. The last-accepted register resets to
//   32'hFFFFFFFF and is reloaded to that value on flush.
module golden_nonce_queue #(
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [31:0]       nonce_in,
    input  logic              nonce_valid,
    input  logic              flush,
    input  logic              tx_busy,
    output logic              tx_send,
    output logic [31:0]       tx_word,
    output logic [ADDR_W:0]   level,
    output logic              overflow,
    output logic [7:0]        drop_count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACK   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};
    // ACK is left after 255 cycles without busy: counter runs 0..254.
    localparam logic [7:0] ACK_LAST = 8'd254;

    logic [31:0]     mem_r [DEPTH];
    logic [ADDR_W:0] wr_r;
    logic [ADDR_W:0] rd_r;
    logic [ADDR_W:0] level_r;
    logic            overflow_r;
    logic [7:0]      drop_count_r;
    state_t          state_r;
    logic [7:0]      ack_cnt_r;
    logic            tx_send_r;
    logic [31:0]     tx_word_r;

    logic            full_s;
    logic            empty_s;
    logic            dup_s;
    logic            push_req_s;
    logic            push_s;
    logic            drop_push_s;
    logic            launch_s;
    logic            timeout_s;
    logic [ADDR_W:0] wr_next_s;
    logic [ADDR_W:0] rd_next_s;
    logic [ADDR_W:0] level_next_s;
    logic [1:0]      drop_inc_s;
    logic [8:0]      drop_sum_s;
    logic [7:0]      drop_next_s;

`ifdef GOLDEN_NONCE_DEDUP_EN
    logic [31:0]     last_r;
`endif

    // Queue status, push/pop decisions and next-state pointer arithmetic.
    always_comb begin
        full_s  = (wr_r[ADDR_W-1:0] == rd_r[ADDR_W-1:0]) && (wr_r[ADDR_W] != rd_r[ADDR_W]);
        empty_s = (wr_r == rd_r);
`ifdef GOLDEN_NONCE_DEDUP_EN
        dup_s = (nonce_in == last_r);
`else
        dup_s = 1'b0;
`endif
        // A push coinciding with flush belongs to stale work: neither stored nor counted.
        push_req_s  = nonce_valid && !flush && !dup_s;
        // full is taken before any same-cycle pop, so a push on a full queue is dropped.
        push_s      = push_req_s && !full_s;
        drop_push_s = push_req_s && full_s;
        launch_s    = (state_r == ST_IDLE) && !empty_s && !tx_busy && !flush;
        timeout_s   = (state_r == ST_ACK) && !tx_busy && (ack_cnt_r == ACK_LAST);

        if (push_s) begin
            wr_next_s = wr_r + PTR_ONE;
        end else begin
            wr_next_s = wr_r;
        end

        if (flush) begin
            rd_next_s = wr_r;
        end else if (launch_s) begin
            rd_next_s = rd_r + PTR_ONE;
        end else begin
            rd_next_s = rd_r;
        end

        level_next_s = wr_next_s - rd_next_s;

        // A dropped push and an ACK timeout may land in the same cycle.
        drop_inc_s = {1'b0, drop_push_s} + {1'b0, timeout_s};
        drop_sum_s = {1'b0, drop_count_r} + {7'd0, drop_inc_s};
        if (drop_sum_s[8]) begin
            drop_next_s = 8'hFF;
        end else begin
            drop_next_s = drop_sum_s[7:0];
        end
    end

    // Pointers, occupancy and drop bookkeeping.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_r         <= {(ADDR_W+1){1'b0}};
            rd_r         <= {(ADDR_W+1){1'b0}};
            level_r      <= {(ADDR_W+1){1'b0}};
            overflow_r   <= 1'b0;
            drop_count_r <= 8'd0;
        end else begin
            wr_r         <= wr_next_s;
            rd_r         <= rd_next_s;
            level_r      <= level_next_s;
            drop_count_r <= drop_next_s;
            if (drop_push_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Storage array; contents need no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_r[ADDR_W-1:0]] <= nonce_in;
        end
    end

    // Launch FSM: IDLE launches one word, ACK waits for busy, DRAIN waits for idle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r   <= ST_IDLE;
            ack_cnt_r <= 8'd0;
            tx_send_r <= 1'b0;
            tx_word_r <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    ack_cnt_r <= 8'd0;
                    if (launch_s) begin
                        tx_send_r <= 1'b1;
                        tx_word_r <= mem_r[rd_r[ADDR_W-1:0]];
                        state_r   <= ST_ACK;
                    end else begin
                        tx_send_r <= 1'b0;
                    end
                end
                ST_ACK: begin
                    tx_send_r <= 1'b0;
                    if (tx_busy) begin
                        state_r <= ST_DRAIN;
                    end else if (timeout_s) begin
                        state_r <= ST_IDLE;
                    end else begin
                        ack_cnt_r <= ack_cnt_r + 8'd1;
                    end
                end
                ST_DRAIN: begin
                    tx_send_r <= 1'b0;
                    if (!tx_busy) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    tx_send_r <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef GOLDEN_NONCE_DEDUP_EN
    // Last accepted nonce; all-ones marks "nothing accepted since reset/flush".
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last_r <= 32'hFFFFFFFF;
        end else if (flush) begin
            last_r <= 32'hFFFFFFFF;
        end else if (push_s) begin
            last_r <= nonce_in;
        end
    end
`endif

    assign tx_send    = tx_send_r;
    assign tx_word    = tx_word_r;
    assign level      = level_r;
    assign overflow   = overflow_r;
    assign drop_count = drop_count_r;

endmodule

// File: tb/tb_golden_nonce_queue.sv
// Directed bench for golden_nonce_queue with a transmitter model and a
// scoreboard of expected transmitted words.
module tb_golden_nonce_queue;

    logic        clk;
    logic        reset_n;
    logic [31:0] nonce_in;
    logic        nonce_valid;
    logic        flush;
    logic        tx_busy;
    logic        tx_send;
    logic [31:0] tx_word;
    logic [3:0]  level;
    logic        overflow;
    logic [7:0]  drop_count;

    logic        force_busy;
    logic        model_en;
    logic [5:0]  busy_cnt;
    logic        prev_send;

    int          n_vec;
    int          n_err;
    int          sends;
    logic [31:0] exp_q[$];

    golden_nonce_queue #(.ADDR_W(3)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .nonce_in   (nonce_in),
        .nonce_valid(nonce_valid),
        .flush      (flush),
        .tx_busy    (tx_busy),
        .tx_send    (tx_send),
        .tx_word    (tx_word),
        .level      (level),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign tx_busy = force_busy | (busy_cnt != 6'd0);

    // Transmitter model: busy for 40 cycles after each accepted send.
    always @(posedge clk) begin
        if (!reset_n) begin
            busy_cnt <= 6'd0;
        end else if (model_en && tx_send) begin
            busy_cnt <= 6'd40;
        end else if (busy_cnt != 6'd0) begin
            busy_cnt <= busy_cnt - 6'd1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic push(input logic [31:0] w, input bit expect_out);
        nonce_in    = w;
        nonce_valid = 1'b1;
        if (expect_out) exp_q.push_back(w);
        tick();
        nonce_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input int bound);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < bound) begin
            tick();
            k++;
        end
        check(tag, exp_q.size(), 0);
    endtask

    // Output monitor: every launch pops the scoreboard, never back-to-back.
    always @(posedge clk) begin
        #1;
        if (reset_n) begin
            if (tx_send) begin
                sends++;
                check("no_back_to_back", {31'd0, prev_send}, 32'd0);
                check("busy_low_at_send", {31'd0, tx_busy}, 32'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_send", 32'd1, 32'd0);
                end else begin
                    check("tx_word", tx_word, exp_q.pop_front());
                end
            end
            prev_send = tx_send;
        end else begin
            prev_send = 1'b0;
        end
    end

    initial begin
        int s0;
        int k;
        n_vec = 0; n_err = 0; sends = 0;
        prev_send   = 1'b0;
        reset_n     = 1'b0;
        nonce_in    = 32'd0;
        nonce_valid = 1'b0;
        flush       = 1'b0;
        force_busy  = 1'b0;
        model_en    = 1'b1;

        // Reset state.
        ticks(3);
        check("rst_tx_send", {31'd0, tx_send}, 32'd0);
        check("rst_tx_word", tx_word, 32'd0);
        check("rst_level", {28'd0, level}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        check("rst_drop_count", {24'd0, drop_count}, 32'd0);
        reset_n = 1'b1;
        tick();

        // Single word latency: tx_send two cycles after the push.
        push(32'h0000318F, 1'b1);
        check("lat_level_1", {28'd0, level}, 32'd1);
        check("lat_send_early", {31'd0, tx_send}, 32'd0);
        tick();
        check("lat_send", {31'd0, tx_send}, 32'd1);
        check("lat_word", tx_word, 32'h0000318F);
        check("lat_level_0", {28'd0, level}, 32'd0);
        tick();
        check("lat_send_pulse", {31'd0, tx_send}, 32'd0);
        check("lat_word_held", tx_word, 32'h0000318F);
        ticks(60);

        // Burst of 10 while busy: 8 stored, 2 dropped, then drained in order.
        force_busy = 1'b1;
        for (int i = 0; i < 10; i++) push(32'hA0000000 + i, i < 8);
        check("burst_level", {28'd0, level}, 32'd8);
        check("burst_overflow", {31'd0, overflow}, 32'd1);
        check("burst_drops", {24'd0, drop_count}, 32'd2);
        force_busy = 1'b0;
        wait_drain("burst_drain", 600);
        ticks(60);
        check("burst_level_end", {28'd0, level}, 32'd0);

        // Flush with a simultaneous push: queue emptied, push not counted.
        force_busy = 1'b1;
        for (int i = 0; i < 3; i++) push(32'hB0000000 + i, 1'b0);
        check("flush_pre_level", {28'd0, level}, 32'd3);
        nonce_in    = 32'hB0000003;
        nonce_valid = 1'b1;
        flush       = 1'b1;
        tick();
        nonce_valid = 1'b0;
        flush       = 1'b0;
        check("flush_level", {28'd0, level}, 32'd0);
        check("flush_drops", {24'd0, drop_count}, 32'd2);
        check("flush_overflow_sticky", {31'd0, overflow}, 32'd1);
        s0 = sends;
        force_busy = 1'b0;
        ticks(60);
        check("flush_no_send", sends, s0);

        // Five words through the 40-cycle transmitter model.
        s0 = sends;
        for (int i = 0; i < 5; i++) push(32'hC0000000 + i, 1'b1);
        wait_drain("five_drain", 400);
        ticks(60);
        check("five_sends", sends, s0 + 5);

        // ACK timeout: transmitter never answers.
        model_en = 1'b0;
        s0 = sends;
        push(32'hD0000001, 1'b1);
        tick();
        push(32'hD0000002, 1'b1);
        k = 0;
        while (sends < s0 + 2 && k < 400) begin
            tick();
            k++;
        end
        check("timeout_next_launch", sends, s0 + 2);
        check("timeout_drop_1", {24'd0, drop_count}, 32'd3);
        ticks(270);
        check("timeout_drop_2", {24'd0, drop_count}, 32'd4);
        model_en = 1'b1;

        // Repeated nonce.
        s0 = sends;
        push(32'hDEADBEEF, 1'b1);
`ifdef GOLDEN_NONCE_DEDUP_EN
        push(32'hDEADBEEF, 1'b0);
`else
        push(32'hDEADBEEF, 1'b1);
`endif
        wait_drain("dup_drain", 200);
        ticks(60);
`ifdef GOLDEN_NONCE_DEDUP_EN
        check("dup_sends", sends, s0 + 1);
`else
        check("dup_sends", sends, s0 + 2);
`endif
        check("final_level", {28'd0, level}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
